// File: rtl/jit_cf_pkg.sv
// jit_cf_pkg
// Shared types for the JIT control-flow operand feeder: pairing FSM state
// encoding, the buffered operand-pair record and the kernel operand width.
package jit_cf_pkg;

   localparam int JIT_CF_WIDTH = 8;

   // odd + b + a
   localparam int JIT_CF_PAIR_W = 2 * JIT_CF_WIDTH + 1;

   typedef enum logic {
      PF_IDLE   = 1'b0,
      PF_HAVE_A = 1'b1
   } pf_state_e;

   typedef struct packed {
      logic                    odd;
      logic [JIT_CF_WIDTH-1:0] b;
      logic [JIT_CF_WIDTH-1:0] a;
   } jit_cf_pair_t;

endpackage

// File: rtl/jit_cf_pair_fifo.sv
// jit_cf_pair_fifo
// DEPTH-entry synchronous FIFO holding packed jit_cf_pair_t records.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write request and record (ignored when full)
//   pop                 read request (ignored when empty)
//   head                record at the read pointer
//   full, empty         occupancy flags
module jit_cf_pair_fifo
   import jit_cf_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [JIT_CF_PAIR_W-1:0] push_data,
   input  logic                     pop,
   output logic [JIT_CF_PAIR_W-1:0] head,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

   logic [JIT_CF_PAIR_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]            wr_ptr_q;
   logic [PW-1:0]            rd_ptr_q;
   logic [PW:0]              count_q;
   logic                     do_push;
   logic                     do_pop;

   assign full    = (count_q == FULL_CNT);
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   // Storage is cleared on reset so the head reads zero out of reset.
   // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/jit_cf_pair_feeder.sv
// jit_cf_pair_feeder
// Pairs consecutive bytes of a valid/ready byte stream into (a, b) operand
// pairs, buffers them in a small FIFO and presents the head pair to the
// combinational control-flow kernel under valid/ready.
// Optional build macro: JIT_CF_PAIR_CNT_EN adds the pair_cnt output.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready/in_data   byte input handshake
//   in_last                     end of stream, qualified by the handshake
//   out_valid/out_ready         pair output handshake
//   out_a, out_b                head pair operands (kernel a / b)
//   out_odd                     pair closed by in_last on its first byte
//   pair_cnt                    pairs popped, wraps at 16 bits (optional)
//
// state     | meaning
// ----------+---------------------------------------
// PF_IDLE   | no byte held; next byte opens a pair
// PF_HAVE_A | first byte held in a_q; next byte closes the pair
module jit_cf_pair_feeder
   import jit_cf_pkg::*;
#(
   parameter int WIDTH = JIT_CF_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b,
   output logic             out_odd
`ifdef JIT_CF_PAIR_CNT_EN
   ,
   output logic [15:0]      pair_cnt
`endif
);

   pf_state_e               state_q;
   pf_state_e               state_d;
   logic [WIDTH-1:0]        a_q;
   logic [WIDTH-1:0]        a_d;
   logic                    push;
   jit_cf_pair_t            push_pair;
   logic [JIT_CF_PAIR_W-1:0] head_bits;
   jit_cf_pair_t            head_pair;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    in_fire;
   logic                    out_fire;

   // in_ready depends only on registered occupancy, never on out_ready.
   assign in_ready  = !fifo_full;
   assign in_fire   = in_valid && in_ready;
   assign out_valid = !fifo_empty;
   assign out_fire  = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= PF_IDLE;
         a_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      push      = 1'b0;
      push_pair = '0;
      if (in_fire) begin
         case (state_q)
            PF_IDLE: begin
               if (in_last) begin
                  // Lone final byte: emit it padded with b = 0.
                  push          = 1'b1;
                  push_pair.a   = in_data;
                  push_pair.b   = '0;
                  push_pair.odd = 1'b1;
               end else begin
                  a_d     = in_data;
                  state_d = PF_HAVE_A;
               end
            end
            PF_HAVE_A: begin
               push          = 1'b1;
               push_pair.a   = a_q;
               push_pair.b   = in_data;
               push_pair.odd = 1'b0;
               state_d       = PF_IDLE;
            end
            default: state_d = PF_IDLE;
         endcase
      end
   end

   jit_cf_pair_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_data(push_pair),
      .pop      (out_fire),
      .head     (head_bits),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   assign head_pair = head_bits;
   assign out_a     = head_pair.a;
   assign out_b     = head_pair.b;
   assign out_odd   = head_pair.odd;

`ifdef JIT_CF_PAIR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pair_cnt <= '0;
      end else if (out_fire) begin
         pair_cnt <= pair_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_jit_cf_pair_feeder.sv
module tb_jit_cf_pair_feeder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic       out_odd;
`ifdef JIT_CF_PAIR_CNT_EN
   logic [15:0] pair_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;

   jit_cf_pair_feeder #(.WIDTH(8), .DEPTH(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_a    (out_a),
      .out_b    (out_b),
      .out_odd  (out_odd)
`ifdef JIT_CF_PAIR_CNT_EN
      ,
      .pair_cnt (pair_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [7:0] a, input logic [7:0] b, input logic odd);
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, "_a"}, {24'd0, out_a}, {24'd0, a});
      chk({tag, "_b"}, {24'd0, out_b}, {24'd0, b});
      chk({tag, "_odd"}, {31'd0, out_odd}, {31'd0, odd});
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_cnt++;
   endtask

   // Wrap stimulus: 6 pairs, including the bit-exactness pair (FF, 01).
   logic [7:0] wa [6];
   logic [7:0] wb [6];

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      wa[0] = 8'hFF; wb[0] = 8'h01;
      wa[1] = 8'h11; wb[1] = 8'h22;
      wa[2] = 8'h80; wb[2] = 8'h7F;
      wa[3] = 8'h00; wb[3] = 8'hFF;
      wa[4] = 8'h5A; wb[4] = 8'hA5;
      wa[5] = 8'hC3; wb[5] = 8'h3C;
      tick();
      tick();

      // Reset values
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_a", {24'd0, out_a}, 32'd0);
      chk("rst_out_b", {24'd0, out_b}, 32'd0);
      chk("rst_out_odd", {31'd0, out_odd}, 32'd0);
`ifdef JIT_CF_PAIR_CNT_EN
      chk("rst_pair_cnt", {16'd0, pair_cnt}, 32'd0);
`endif
      rst = 1'b0;
      tick();

      // Basic pair, latency one cycle after the closing byte
      send(8'h03, 1'b0);
      chk("basic_half", {31'd0, out_valid}, 32'd0);
      send(8'h05, 1'b0);
      chk_head("basic", 8'h03, 8'h05, 1'b0);
      pop_one();
      chk("basic_drained", {31'd0, out_valid}, 32'd0);

      // Equal operands, head held stable under backpressure
      send(8'h07, 1'b0);
      send(8'h07, 1'b0);
      chk_head("equal", 8'h07, 8'h07, 1'b0);
      tick();
      chk_head("equal_hold", 8'h07, 8'h07, 1'b0);
      pop_one();

      // Odd tail from PF_IDLE; FSM must stay idle so next two bytes pair up
      send(8'h09, 1'b1);
      chk_head("odd", 8'h09, 8'h00, 1'b1);
      out_ready = 1'b1;
      send(8'h0A, 1'b0);
      out_ready = 1'b0;
      exp_cnt++;
      chk("odd_popped", {31'd0, out_valid}, 32'd0);
      send(8'h0B, 1'b1);
      chk_head("after_odd", 8'h0A, 8'h0B, 1'b0);
      pop_one();

      // Backpressure with DEPTH=2
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_data = 8'(i);
         tick();
         chk($sformatf("bp_ready_%0d", i), {31'd0, in_ready}, (i == 4) ? 32'd0 : 32'd1);
      end
      in_data = 8'd5;
      tick();
      chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
      chk_head("bp_head1", 8'd1, 8'd2, 1'b0);
      out_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("bp_ready_after_pop", {31'd0, in_ready}, 32'd1);
      chk_head("bp_head2", 8'd3, 8'd4, 1'b0);
      tick();
      exp_cnt++;
      chk("bp_byte5_taken_empty", {31'd0, out_valid}, 32'd0);
      out_ready = 1'b0;
      in_data = 8'd6;
      tick();
      in_valid = 1'b0;
      chk_head("bp_head3", 8'd5, 8'd6, 1'b0);
      pop_one();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Reset mid-pair discards the held byte
      send(8'hAA, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
`ifdef JIT_CF_PAIR_CNT_EN
      chk("mid_rst_cnt", {16'd0, pair_cnt}, 32'd0);
`endif
      send(8'h10, 1'b0);
      send(8'h20, 1'b0);
      chk_head("mid_rst_pair", 8'h10, 8'h20, 1'b0);
      pop_one();
      chk("mid_rst_only_one", {31'd0, out_valid}, 32'd0);

      // Pointer wrap: fill to full, drain, three times
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 2; k++) begin
            send(wa[2*g+k], 1'b0);
            send(wb[2*g+k], 1'b0);
         end
         chk($sformatf("wrap_full_%0d", g), {31'd0, in_ready}, 32'd0);
         for (int k = 0; k < 2; k++) begin
            chk_head($sformatf("wrap_%0d", 2*g+k), wa[2*g+k], wb[2*g+k], 1'b0);
            pop_one();
         end
         chk($sformatf("wrap_empty_%0d", g), {31'd0, out_valid}, 32'd0);
      end
`ifdef JIT_CF_PAIR_CNT_EN
      chk("pair_cnt_final", {16'd0, pair_cnt}, exp_cnt);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
